// File: rtl/control_word_sequencer.sv
// control_word_sequencer
// Microprogram sequencer feeding the datapath its 55-bit ControlWord.
// A writable control store is stepped by a micro-PC after a start
// request; branches use the datapath's live status flags, so a branch
// resolves in the same cycle as the word that produced the flags.
// Optional feature: define CWS_WATCHDOG_EN to abort runs that issue
// MAX_CYCLES words without reaching an END word (done + timeout pulse).
module control_word_sequencer #(
   parameter int ADDR_W     = 6,
   parameter int MAX_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  prog_we,
   input  logic [ADDR_W-1:0]     prog_addr,
   input  logic [59+ADDR_W:0]    prog_data,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     start_addr,
   input  logic                  Overflow,
   input  logic                  CarryOut,
   input  logic                  Negative,
   input  logic                  Zero,
   output logic [54:0]           ControlWord,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic [ADDR_W-1:0]     upc
);

   localparam logic [1:0] MODE_NEXT   = 2'b00;
   localparam logic [1:0] MODE_JUMP   = 2'b01;
   localparam logic [1:0] MODE_BRANCH = 2'b10;
   localparam logic [1:0] MODE_END    = 2'b11;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state;
   logic [59+ADDR_W:0]     store [0:(1<<ADDR_W)-1];
   logic [59+ADDR_W:0]     word;
   logic [2:0]             cond;
   logic [1:0]             mode;
   logic [ADDR_W-1:0]      target;
   logic                   cond_true;
   logic [ADDR_W-1:0]      next_upc;

`ifdef CWS_WATCHDOG_EN
   localparam int CNT_W = $clog2(MAX_CYCLES + 1);
   logic [CNT_W-1:0]       count;
   logic                   timeout_r;
   assign timeout = timeout_r;
`else
   assign timeout = 1'b0;
`endif

   // Microword fields decoded straight from the current micro-PC.
   assign word        = store[upc];
   assign cond        = word[57:55];
   assign mode        = word[59:58];
   assign target      = word[59+ADDR_W:60];
   assign busy        = (state == RUN);
   assign ControlWord = (state == RUN) ? word[54:0] : '0;

   // Control store: written only while idle, never cleared by reset.
   always_ff @(posedge clk) begin
      if (prog_we && state == IDLE)
         store[prog_addr] <= prog_data;
   end

   // Branch condition evaluated on the live flags of the issuing word.
   always_comb begin
      cond_true = 1'b0;
      case (cond)
         3'b000:  cond_true = Zero;
         3'b001:  cond_true = !Zero;
         3'b010:  cond_true = Negative;
         3'b011:  cond_true = !Negative;
         3'b100:  cond_true = CarryOut;
         3'b101:  cond_true = Overflow;
         3'b110:  cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

   // Next micro-PC selection; sequential stepping wraps at the top of the store.
   always_comb begin
      next_upc = upc + 1'b1;
      case (mode)
         MODE_JUMP:   next_upc = target;
         MODE_BRANCH: next_upc = cond_true ? target : upc + 1'b1;
         MODE_END:    next_upc = upc;
         default:     next_upc = upc + 1'b1;
      endcase
   end

   // Sequencer FSM with registered done/timeout pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         upc       <= '0;
         done      <= 1'b0;
`ifdef CWS_WATCHDOG_EN
         count     <= '0;
         timeout_r <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef CWS_WATCHDOG_EN
         timeout_r <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  upc   <= start_addr;
`ifdef CWS_WATCHDOG_EN
                  count <= '0;
`endif
               end
            end
            RUN: begin
`ifdef CWS_WATCHDOG_EN
               count <= count + CNT_W'(1);
`endif
               if (mode == MODE_END) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
`ifdef CWS_WATCHDOG_EN
               else if (count == CNT_W'(MAX_CYCLES - 1)) begin
                  state     <= IDLE;
                  done      <= 1'b1;
                  timeout_r <= 1'b1;
               end
`endif
               else begin
                  upc <= next_upc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
